// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the long-latency register scoreboard.
package reg_scoreboard_pkg;

    localparam int SB_NUM_REGS = 32;
    localparam int SB_CNT_W    = 2;
    localparam int REG_ADDR_W  = 5;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic                  long_op;
        logic [REG_ADDR_W-1:0] rd;
    } sb_issue_s;

    // A request only needs tracking when it is a long op writing a real register.
    function automatic logic is_tracked(input sb_issue_s req);
        return req.valid && req.we && req.long_op && (req.rd != '0);
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue / operand / writeback bundle between the pipeline and the scoreboard.
interface reg_scoreboard_if
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = SB_NUM_REGS
);
    logic                  issue_valid_i;
    logic                  issue_we_i;
    logic                  issue_long_i;
    logic [REG_ADDR_W-1:0] issue_rd_i;
    logic [REG_ADDR_W-1:0] id_rs1_i;
    logic [REG_ADDR_W-1:0] id_rs2_i;
    logic                  id_rs1_used_i;
    logic                  id_rs2_used_i;
    logic                  flush_i;
    logic                  wb_valid_i;
    logic [REG_ADDR_W-1:0] wb_rd_i;
    logic                  stall_o;
    logic                  issue_fire_o;
    logic [NUM_REGS-1:0]   pending_o;
    logic                  err_o;

    modport master (
        output issue_valid_i, issue_we_i, issue_long_i, issue_rd_i,
        output id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
        output flush_i, wb_valid_i, wb_rd_i,
        input  stall_o, issue_fire_o, pending_o, err_o
    );

    modport slave (
        input  issue_valid_i, issue_we_i, issue_long_i, issue_rd_i,
        input  id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
        input  flush_i, wb_valid_i, wb_rd_i,
        output stall_o, issue_fire_o, pending_o, err_o
    );
endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// Per-register saturating up/down in-flight counter with underflow flag.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             underflow
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            case ({inc, dec})
                2'b10: if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + CNT_W'(1);
                2'b01: if (cnt_reg != '0)      cnt_reg <= cnt_reg - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign cnt       = cnt_reg;
    // Simultaneous inc/dec nets out, so only a lone decrement can underflow.
    assign underflow = dec && !inc && (cnt_reg == '0);
endmodule

// File: rtl/reg_scoreboard.sv
// Long-latency destination scoreboard driving the ID-stage stall.
// SB_WB_BYPASS_EN: a source whose last in-flight write retires this cycle does not stall.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = SB_NUM_REGS,
    parameter int CNT_W    = SB_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    reg_scoreboard_if.slave   sb
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:1] underflow;
    logic [NUM_REGS-1:0] pending;
    logic                err_reg;
    sb_issue_s           issue;
    logic                track_req;
    logic                inc_fire;
    logic                rs1_byp;
    logic                rs2_byp;
    logic                stall;

    assign issue     = '{valid:   sb.issue_valid_i,
                         we:      sb.issue_we_i,
                         long_op: sb.issue_long_i,
                         rd:      sb.issue_rd_i};
    assign track_req = is_tracked(issue);
    assign inc_fire  = track_req && sb.issue_fire_o;

    assign cnt[0]     = '0;
    assign pending[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
            sb_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk       (clk_i),
                .rst       (rst_i),
                .inc       (inc_fire && (sb.issue_rd_i == REG_ADDR_W'(gi))),
                .dec       (sb.wb_valid_i && (sb.wb_rd_i == REG_ADDR_W'(gi))),
                .cnt       (cnt[gi]),
                .underflow (underflow[gi])
            );
            assign pending[gi] = (cnt[gi] != '0);
        end
    endgenerate

`ifdef SB_WB_BYPASS_EN
    // The retiring value is forwarded, so the last outstanding write no longer blocks.
    assign rs1_byp = sb.wb_valid_i && (sb.wb_rd_i == sb.id_rs1_i) && (cnt[sb.id_rs1_i] == CNT_W'(1));
    assign rs2_byp = sb.wb_valid_i && (sb.wb_rd_i == sb.id_rs2_i) && (cnt[sb.id_rs2_i] == CNT_W'(1));
`else
    assign rs1_byp = 1'b0;
    assign rs2_byp = 1'b0;
`endif

    always_comb begin
        stall = 1'b0;
        if (sb.id_rs1_used_i && (sb.id_rs1_i != '0) && (cnt[sb.id_rs1_i] != '0) && !rs1_byp)
            stall = 1'b1;
        if (sb.id_rs2_used_i && (sb.id_rs2_i != '0) && (cnt[sb.id_rs2_i] != '0) && !rs2_byp)
            stall = 1'b1;
        // A saturated counter cannot record another in-flight write.
        if (track_req && (cnt[sb.issue_rd_i] == CNT_MAX))
            stall = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)           err_reg <= 1'b0;
        else if (|underflow) err_reg <= 1'b1;
    end

    assign sb.stall_o      = stall;
    assign sb.issue_fire_o = sb.issue_valid_i && !stall && !sb.flush_i;
    assign sb.pending_o    = pending;
    assign sb.err_o        = err_reg;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized and directed bench for reg_scoreboard against an integer-array model.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    localparam int MAXC = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cnt_m [32];
    bit   err_m;

    reg_scoreboard_if #(.NUM_REGS(32)) sb ();

    reg_scoreboard #(.NUM_REGS(32), .CNT_W(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .sb    (sb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] pend_m();
        logic [31:0] p;
        for (int r = 0; r < 32; r++) p[r] = (cnt_m[r] != 0);
        return p;
    endfunction

    function automatic bit src_blocks(input bit used, input int rs, input bit wbv, input int wbrd);
        bit b;
        b = used && rs != 0 && cnt_m[rs] > 0;
`ifdef SB_WB_BYPASS_EN
        if (wbv && wbrd == rs && cnt_m[rs] == 1) b = 0;
`else
        if (wbv && wbrd < 0) b = 0;
`endif
        return b;
    endfunction

    task automatic idle();
        sb.issue_valid_i = 0; sb.issue_we_i = 0; sb.issue_long_i = 0; sb.issue_rd_i = 0;
        sb.id_rs1_i = 0; sb.id_rs2_i = 0; sb.id_rs1_used_i = 0; sb.id_rs2_used_i = 0;
        sb.flush_i = 0; sb.wb_valid_i = 0; sb.wb_rd_i = 0;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit v, input bit we, input bit lg, input int rd,
                        input int rs1, input bit u1, input int rs2, input bit u2,
                        input bit fl, input bit wbv, input int wbrd);
        bit es, ef;
        int inc_r, dec_r;
        sb.issue_valid_i = v; sb.issue_we_i = we; sb.issue_long_i = lg; sb.issue_rd_i = 5'(rd);
        sb.id_rs1_i = 5'(rs1); sb.id_rs1_used_i = u1; sb.id_rs2_i = 5'(rs2); sb.id_rs2_used_i = u2;
        sb.flush_i = fl; sb.wb_valid_i = wbv; sb.wb_rd_i = 5'(wbrd);
        #1;
        es = src_blocks(u1, rs1, wbv, wbrd) || src_blocks(u2, rs2, wbv, wbrd) ||
             (v && we && lg && rd != 0 && cnt_m[rd] == MAXC);
        ef = v && !es && !fl;
        $display("t=%0t v=%0b we=%0b lg=%0b rd=%0d rs1=%0d/%0b rs2=%0d/%0b fl=%0b wb=%0b/%0d -> stall=%0b fire=%0b pend=%h err=%0b",
                 $time, v, we, lg, rd, rs1, u1, rs2, u2, fl, wbv, wbrd,
                 sb.stall_o, sb.issue_fire_o, sb.pending_o, sb.err_o);
        check("stall",   32'(sb.stall_o),      32'(es));
        check("fire",    32'(sb.issue_fire_o), 32'(ef));
        check("pending", sb.pending_o,         pend_m());
        check("err",     32'(sb.err_o),        32'(err_m));
        @(posedge clk);
        inc_r = (ef && we && lg && rd != 0) ? rd : -1;
        dec_r = (wbv && wbrd != 0) ? wbrd : -1;
        if (inc_r != dec_r) begin
            if (inc_r > 0 && cnt_m[inc_r] < MAXC) cnt_m[inc_r]++;
            if (dec_r > 0) begin
                if (cnt_m[dec_r] == 0) err_m = 1;
                else cnt_m[dec_r]--;
            end
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        err_m = 0;
    endtask

    initial begin
        model_reset();
        idle();
        #12;
        check("rst_pending", sb.pending_o,         32'd0);
        check("rst_err",     32'(sb.err_o),        32'd0);
        check("rst_stall",   32'(sb.stall_o),      32'd0);
        check("rst_fire",    32'(sb.issue_fire_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Load to x5, dependent op waits until writeback.
        step(1,1,1,5, 0,0,0,0, 0,0,0);
        for (int i = 0; i < 3; i++) step(1,1,0,6, 5,1,0,0, 0,0,0);
        step(1,1,0,6, 5,1,0,0, 0,1,5);
        step(1,1,0,6, 5,1,0,0, 0,0,0);
        check("x5_clear", 32'(sb.pending_o[5]), 32'd0);

        // Saturation of x7.
        for (int i = 0; i < 4; i++) step(1,1,1,7, 0,0,0,0, 0,0,0);
        step(1,1,1,7, 0,0,0,0, 0,1,7);
        step(1,1,1,7, 0,0,0,0, 0,0,0);
        for (int i = 0; i < 3; i++) step(0,0,0,0, 0,0,0,0, 0,1,7);

        // Same-cycle issue and writeback on x9.
        step(1,1,1,9, 0,0,0,0, 0,0,0);
        step(1,1,1,9, 0,0,0,0, 0,1,9);
        check("x9_held", 32'(sb.pending_o[9]), 32'd1);
        step(0,0,0,0, 0,0,0,0, 0,1,9);

        // x0 is never tracked nor a hazard.
        step(1,1,1,0, 0,1,0,1, 0,0,0);
        step(1,1,0,1, 0,1,0,1, 0,0,0);

        // Flushed long issue is not recorded.
        step(1,1,1,3, 0,0,0,0, 1,0,0);
        check("x3_flush", 32'(sb.pending_o[3]), 32'd0);

        // Underflow is sticky, then asynchronous reset clears everything.
        step(0,0,0,0, 0,0,0,0, 0,1,12);
        step(1,1,1,4, 12,1,0,0, 0,0,0);
        step(0,0,0,0, 4,1,0,0, 0,0,0);
        idle();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst_pending", sb.pending_o,         32'd0);
        check("arst_err",     32'(sb.err_o),        32'd0);
        check("arst_stall",   32'(sb.stall_o),      32'd0);
        check("arst_fire",    32'(sb.issue_fire_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Random traffic over a small register window to provoke hazards.
        for (int i = 0; i < 300; i++) begin
            int wr;
            bit wv;
            wr = $urandom_range(1, 7);
            wv = (cnt_m[wr] > 0) && ($urandom_range(0, 2) == 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0, wv, wv ? wr : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
